// File: rtl/fxdiv_pkg.sv
// Shared types and helpers for the signed fixed-point sequential divider.
// Helpers work on a 64-bit carrier; callers pass their real width and truncate.
package fxdiv_pkg;

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} fxdiv_state_t;

  localparam int unsigned FXDIV_MAX_W = 64;

  function automatic logic [FXDIV_MAX_W-1:0] fxdiv_mask(input int unsigned w);
    return (w >= FXDIV_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Magnitude of a w-bit two's-complement value; -2^(w-1) maps to 2^(w-1).
  function automatic logic [FXDIV_MAX_W-1:0] fxdiv_abs(input logic [FXDIV_MAX_W-1:0] v,
                                                       input int unsigned w);
    logic [FXDIV_MAX_W-1:0] m, r;
    m = fxdiv_mask(w);
    r = v & m;
    if (r[w-1]) r = ((~r) + 64'd1) & m;
    return r;
  endfunction

  function automatic logic [FXDIV_MAX_W-1:0] fxdiv_max_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern of -2^(w-1); numerically equal to the largest negative magnitude.
  function automatic logic [FXDIV_MAX_W-1:0] fxdiv_min_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fxdiv_restoring_step.sv
// One restoring long-division step: shift in a dividend bit, subtract if it fits.
module fxdiv_restoring_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted, diff;

  assign shifted  = {rem, bit_in};
  assign q_bit    = (shifted >= {2'b00, divisor});
  assign diff     = shifted - {2'b00, divisor};
  // Remainder stays below |divisor| <= 2^(WIDTH-1), so the top bit is always zero.
  assign rem_next = (WIDTH+1)'(q_bit ? diff : shifted);

endmodule

// File: rtl/fixed_point_signed_seq_divider.sv
// Signed Q(WIDTH-FRAC).FRAC divider, one quotient bit per clock, with saturation
// and divide-by-zero reporting behind valid/ready handshakes.
module fixed_point_signed_seq_divider
  import fxdiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_overflow,
  output logic             o_div_by_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [WIDTH-1:0] MAX_POS   = WIDTH'(fxdiv_max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG   = WIDTH'(fxdiv_min_neg(WIDTH));
  localparam logic [N-1:0]     MAX_POS_N = N'(fxdiv_max_pos(WIDTH));
  localparam logic [N-1:0]     MAX_NEG_N = N'(fxdiv_min_neg(WIDTH));

  fxdiv_state_t state, nxt;

  logic             sign_q, a_neg, dbz;
  logic [WIDTH-1:0] dmag;
  logic [N-1:0]     dvd_sr, q_mag, q_neg;
  logic [WIDTH:0]   rem, rem_nxt;
  logic             qbit;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] fix_q;
  logic             fix_ovf;

  fxdiv_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (dvd_sr[N-1]),
    .divisor  (dmag),
    .rem_next (rem_nxt),
    .q_bit    (qbit)
  );

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (i_valid) nxt = DIV;
      DIV:  if (cnt == CW'(1)) nxt = FIX;
      FIX:  nxt = DONE;
      DONE: if (i_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb o_ready = (state == IDLE);

  // Final result selection; priority is divide-by-zero, then saturation, then signed magnitude.
  always_comb begin
    q_neg   = N'(0) - q_mag;
    fix_q   = sign_q ? q_neg[WIDTH-1:0] : q_mag[WIDTH-1:0];
    fix_ovf = 1'b0;
    if (dbz) begin
      fix_q = a_neg ? MIN_NEG : MAX_POS;
    end else if (!sign_q && q_mag > MAX_POS_N) begin
      fix_q   = MAX_POS;
      fix_ovf = 1'b1;
    end else if (sign_q && q_mag > MAX_NEG_N) begin
      fix_q   = MIN_NEG;
      fix_ovf = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q        <= 1'b0;
      a_neg         <= 1'b0;
      dbz           <= 1'b0;
      dmag          <= '0;
      dvd_sr        <= '0;
      q_mag         <= '0;
      rem           <= '0;
      cnt           <= '0;
      o_valid       <= 1'b0;
      o_quotient    <= '0;
      o_overflow    <= 1'b0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
          a_neg  <= i_dividend[WIDTH-1];
          dbz    <= (i_divisor == '0);
          dmag   <= WIDTH'(fxdiv_abs(64'(i_divisor), WIDTH));
          dvd_sr <= N'(fxdiv_abs(64'(i_dividend), WIDTH)) << FRAC;
          q_mag  <= '0;
          rem    <= '0;
          cnt    <= CW'(N);
        end
        DIV: begin
          rem    <= rem_nxt;
          q_mag  <= {q_mag[N-2:0], qbit};
          dvd_sr <= dvd_sr << 1;
          cnt    <= cnt - CW'(1);
        end
        FIX: begin
          o_quotient    <= fix_q;
          o_overflow    <= fix_ovf;
          o_div_by_zero <= dbz;
          o_valid       <= 1'b1;
        end
        DONE: if (i_ready) o_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_signed_seq_divider.sv
// Directed scoreboard bench for the Q8.8 sequential divider.
module tb_fixed_point_signed_seq_divider;

  logic        i_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [15:0] i_dividend = '0;
  logic [15:0] i_divisor = '0;
  logic        o_ready, o_valid, o_overflow, o_div_by_zero;
  logic [15:0] o_quotient;

  fixed_point_signed_seq_divider #(.WIDTH(16), .FRAC(8)) dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .o_valid(o_valid),
    .i_ready(i_ready), .o_quotient(o_quotient), .o_overflow(o_overflow),
    .o_div_by_zero(o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a result is consumed on the edge following a sample with valid and ready high.
  always @(negedge i_clk) begin
    if (reset_n && o_valid && i_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 32'(o_quotient), 32'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("quotient", 32'(o_quotient), 32'(e.q));
        check("overflow", 32'(o_overflow), 32'(e.ovf));
        check("div_by_zero", 32'(o_div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!o_ready && t < 200) begin tick(); t++; end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic ovf, input logic dbz, input bit push);
    exp_t e;
    wait_ready();
    i_dividend = a;
    i_divisor  = b;
    i_valid    = 1'b1;
    e.q = q; e.ovf = ovf; e.dbz = dbz;
    if (push) sbq.push_back(e);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || o_valid) && t < 200) begin tick(); t++; end
    if (sbq.size() != 0 || o_valid) check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a, b, q;
    logic        ovf, dbz;
  } vec_t;

  vec_t vecs[9] = '{
    '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0},
    '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0},
    '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0},
    '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0},
    '{16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0},
    '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0},
    '{16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1},
    '{16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [15:0] held;

    repeat (2) tick();
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_quotient", 32'(o_quotient), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_dbz", 32'(o_div_by_zero), 32'd0);
    reset_n = 1'b1;
    tick();

    // 3.0 / 2.0 with latency and ready-return timing
    issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!o_valid && n < 60) begin tick(); n++; end
    check("latency", 32'(n), 32'd25);
    check("ready_in_done", 32'(o_ready), 32'd0);
    tick();
    check("ready_after_handshake", 32'(o_ready), 32'd1);
    check("valid_after_handshake", 32'(o_valid), 32'd0);
    drain();

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf, vecs[i].dbz, 1'b1);
      drain();
    end

    // Backpressure: result held stable in DONE
    i_ready = 1'b0;
    issue(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!o_valid && n < 60) begin tick(); n++; end
    check("bp_valid_seen", 32'(o_valid), 32'd1);
    held = o_quotient;
    bad = 0;
    repeat (10) begin
      tick();
      if (!(o_valid && o_quotient == held && !o_ready)) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    check("bp_held_value", 32'(held), 32'h0055);
    i_ready = 1'b1;
    drain();

    // Busy: i_valid pulsed mid-DIV must be ignored
    issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    check("busy_not_ready", 32'(o_ready), 32'd0);
    i_dividend = 16'h7F00;
    i_divisor  = 16'h0080;
    i_valid    = 1'b1;
    tick();
    i_valid = 1'b0;
    drain();

    // Reset mid-DIV aborts; a fresh operation then completes
    issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    check("pre_reset_busy", 32'(o_ready), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(o_ready), 32'd1);
    check("async_rst_valid", 32'(o_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b1);
    drain();

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fixed_point_signed_seq_divider.md
# fixed_point_signed_seq_divider

Parametrised, multi-cycle signed fixed-point divider for the DSP filter datapath, generalising the 8-bit fixed-point long divider. Computes quotient = dividend / divisor in two's-complement Q(WIDTH-FRAC).FRAC using a restoring long division that produces one quotient bit per clock. Adds a valid/ready handshake on both sides, saturation on overflow, and divide-by-zero reporting.

## Interface
- WIDTH, 16: total operand and result width in bits (≥ 4).
- FRAC, 8: fractional bits, 0 ≤ FRAC < WIDTH; operands and result share the same format.
- Clock and reset: one clock `i_clk`; reset `reset_n` is asynchronous and active-low.
- i_clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operand pair valid.
- o_ready  out  1  block idle and able to accept; equals (state == IDLE).
- i_dividend  in  WIDTH  signed dividend.
- i_divisor  in  WIDTH  signed divisor.
- o_valid  out  1  result valid; held until consumed.
- i_ready  in  1  downstream accepts the result.
- o_quotient  out  WIDTH  signed quotient, same Q format as the operands.
- o_overflow  out  1  quotient was saturated.
- o_div_by_zero  out  1  divisor was 0.

## Operation
- States: IDLE, DIV, FIX, DONE.
- IDLE: o_ready = 1. When i_valid is high at an edge:
  - Capture sign_q = sign(dividend) XOR sign(divisor).
  - Capture |dividend| and |divisor| as WIDTH-bit unsigned values, so |−2^(WIDTH−1)| = 2^(WIDTH−1) is representable.
  - Capture the zero-divisor flag.
  - Clear remainder R (WIDTH+1 bits) and quotient magnitude Q (N = WIDTH+FRAC bits).
  - Load counter = N, then go to DIV.
- DIV: one restoring step per cycle. The extended dividend is {|dividend|, FRAC zeros}, consumed MSB first.
  - R' = {R, next bit}.
  - If R' ≥ |divisor|: R = R' − |divisor| and shift 1 into Q; otherwise R = R' and shift 0 into Q.
  - The counter decrements each step. After the N-th step, go to FIX.
- FIX, applied to the registered result in this order:
  - Divide-by-zero: o_div_by_zero = 1, o_overflow = 0. Result is 2^(WIDTH−1)−1 if the dividend is ≥ 0, else −2^(WIDTH−1).
  - Positive sign, Q > 2^(WIDTH−1)−1: result = 2^(WIDTH−1)−1, o_overflow = 1.
  - Negative sign, Q > 2^(WIDTH−1): result = −2^(WIDTH−1), o_overflow = 1.
  - Otherwise: result = sign_q ? −Q : Q, truncated toward zero. A zero magnitude gives 0 regardless of sign.
  - Then go to DONE.
- DONE: o_valid = 1, with o_quotient and both flags stable.
  - If i_ready is high at an edge, go to IDLE and clear o_valid.
  - Holds indefinitely while i_ready is low.
- Operands are sampled only at acceptance; later input changes have no effect.
- i_valid is ignored while o_ready = 0; no queueing.

## Timing
- Reset values: state IDLE, o_ready 1, o_valid 0, o_quotient 0, o_overflow 0, o_div_by_zero 0.
- Latency: for acceptance at edge k, o_valid is first high after edge k+N+1 (N DIV edges plus 1 FIX edge).
- Divide-by-zero and overflow cases take the same latency.
- Throughput: one operation per N+3 cycles when i_ready is held high. That is acceptance, N DIV, FIX, and the DONE hand-off, then IDLE re-accepts on the next edge.
- o_ready is not asserted in DONE, even when i_ready = 1.
- Reset asserted mid-operation (DIV/FIX/DONE) aborts immediately. Outputs return to their reset values; no partial result is ever presented.
- All outputs are registered except o_ready, which is decoded from the state register.

## Structure
- Package `fxdiv_pkg`:
  - State enum `fxdiv_state_t` (IDLE, DIV, FIX, DONE).
  - Function `fxdiv_abs` returning the WIDTH-bit unsigned magnitude.
  - Functions for the saturation limits max_pos and min_neg, parametrised by width.
- Sub-module `fxdiv_restoring_step`: purely combinational single step.
  - Inputs: R, next bit, |divisor|.
  - Outputs: new R and quotient bit.
  - Instantiated once in the top block, which owns the counter, the shift registers and the FSM.

## Test plan
Defaults WIDTH = 16, FRAC = 8 (Q8.8), i_ready held high unless stated.
- 0x0300 / 0x0200 (3.0 / 2.0) -> 0x0180; o_valid first high 25 cycles after the acceptance edge; o_ready returns to 1 one cycle after the handshake.
- Signs and truncation:
  - 0xFD00 / 0x0200 -> 0xFE80.
  - 0x0100 / 0x0300 -> 0x0055.
  - 0xFF00 / 0x0300 -> 0xFFAB (truncated toward zero).
  - 0x8000 / 0x0100 -> 0x8000 with no overflow.
- Saturation:
  - 0x7F00 / 0x0080 -> 0x7FFF with o_overflow = 1.
  - 0x8000 / 0xFF00 -> 0x7FFF with o_overflow = 1.
- Divide-by-zero:
  - 0x0100 / 0x0000 -> 0x7FFF with o_div_by_zero = 1.
  - 0xFF00 / 0x0000 -> 0x8000 with o_div_by_zero = 1.
  - 0x0000 / 0x0000 -> 0x7FFF.
- Backpressure and busy behaviour:
  - Hold i_ready low for 10 cycles in DONE: o_valid and o_quotient stay stable.
  - Pulse i_valid with different operands during DIV: ignored, and the result still matches the first operands.
- Reset: drop reset_n mid-DIV (counter around 12) -> o_valid 0 and o_ready 1 asynchronously; a fresh 0x0300 / 0x0200 after release completes correctly to 0x0180.
